// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display path.
// Segment patterns, bit positions and line polarities are used by both the scanner and the decoder.
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Anodes and segments are both driven low to light.
  localparam logic ANODE_ON = 1'b0;
  localparam logic SEG_ON   = 1'b0;

  localparam logic [6:0] SEG_PAT_0 = 7'h3F;
  localparam logic [6:0] SEG_PAT_1 = 7'h06;
  localparam logic [6:0] SEG_PAT_2 = 7'h5B;
  localparam logic [6:0] SEG_PAT_3 = 7'h4F;
  localparam logic [6:0] SEG_PAT_4 = 7'h66;
  localparam logic [6:0] SEG_PAT_5 = 7'h6D;
  localparam logic [6:0] SEG_PAT_6 = 7'h7D;
  localparam logic [6:0] SEG_PAT_7 = 7'h07;
  localparam logic [6:0] SEG_PAT_8 = 7'h7F;
  localparam logic [6:0] SEG_PAT_9 = 7'h6F;
  localparam logic [6:0] SEG_PAT_A = 7'h77;
  localparam logic [6:0] SEG_PAT_B = 7'h7C;
  localparam logic [6:0] SEG_PAT_C = 7'h39;
  localparam logic [6:0] SEG_PAT_D = 7'h5E;
  localparam logic [6:0] SEG_PAT_E = 7'h79;
  localparam logic [6:0] SEG_PAT_F = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    SETTLE = 1'b0,
    HELD   = 1'b1
  } scan_state_e;

  // Active-high gfedcba pattern for a hex value, as the scanner drives it.
  function automatic logic [6:0] seg7_encode(input logic [3:0] value);
    logic [6:0] pat;
    case (value)
      4'h0: pat = SEG_PAT_0;
      4'h1: pat = SEG_PAT_1;
      4'h2: pat = SEG_PAT_2;
      4'h3: pat = SEG_PAT_3;
      4'h4: pat = SEG_PAT_4;
      4'h5: pat = SEG_PAT_5;
      4'h6: pat = SEG_PAT_6;
      4'h7: pat = SEG_PAT_7;
      4'h8: pat = SEG_PAT_8;
      4'h9: pat = SEG_PAT_9;
      4'hA: pat = SEG_PAT_A;
      4'hB: pat = SEG_PAT_B;
      4'hC: pat = SEG_PAT_C;
      4'hD: pat = SEG_PAT_D;
      4'hE: pat = SEG_PAT_E;
      4'hF: pat = SEG_PAT_F;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Scan-line bundle between a 7-segment scanner (master) and the scan decoder (slave),
// including the decoder's reconstructed display state.
interface seg7_scan_decoder_if #(
  parameter int ANODES = 4,
  parameter int SEG_7  = 8
);
  logic [ANODES-1:0]   anodes;
  logic [SEG_7-1:0]    segments;
  logic                err_clr;
  logic [4*ANODES-1:0] digits;
  logic [ANODES-1:0]   dots;
  logic [ANODES-1:0]   blank;
  logic                frame_valid;
  logic                code_err;
  logic                overlap_err;

  modport master (
    output anodes, segments, err_clr,
    input  digits, dots, blank, frame_valid, code_err, overlap_err
  );

  modport slave (
    input  anodes, segments, err_clr,
    output digits, dots, blank, frame_valid, code_err, overlap_err
  );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Maps an active-high gfedcba pattern back to its hex value.
// The all-off pattern is reported as blank; anything outside the glyph table is invalid.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       blank,
  output logic       invalid
);

  // Glyph table lookup
  always_comb begin
    value   = 4'h0;
    blank   = 1'b0;
    invalid = 1'b0;
    case (pattern)
      SEG_PAT_0: value = 4'h0;
      SEG_PAT_1: value = 4'h1;
      SEG_PAT_2: value = 4'h2;
      SEG_PAT_3: value = 4'h3;
      SEG_PAT_4: value = 4'h4;
      SEG_PAT_5: value = 4'h5;
      SEG_PAT_6: value = 4'h6;
      SEG_PAT_7: value = 4'h7;
      SEG_PAT_8: value = 4'h8;
      SEG_PAT_9: value = 4'h9;
      SEG_PAT_A: value = 4'hA;
      SEG_PAT_B: value = 4'hB;
      SEG_PAT_C: value = 4'hC;
      SEG_PAT_D: value = 4'hD;
      SEG_PAT_E: value = 4'hE;
      SEG_PAT_F: value = 4'hF;
      SEG_BLANK: blank = 1'b1;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of the multiplexed 7-segment scan: waits for each scan pattern to settle,
// captures digit/dp/blank per position, and reports frame completion and illegal scan states.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int ANODES     = 4,
  parameter int SEG_7      = 8,
  parameter int STABLE_CYC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_decoder_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int SW = ANODES + SEG_7;
  localparam int IW = (ANODES > 1) ? $clog2(ANODES) : 1;

  localparam logic [SW-1:0] IDLE_SMP = {{ANODES{~ANODE_ON}}, {SEG_7{~SEG_ON}}};

  logic [SW-1:0]       smp_r;
  logic [SW-1:0]       prev_r;
  logic [CW-1:0]       cnt_r;
  scan_state_e         state_r;
  logic [ANODES-1:0]   seen_r;
  logic                ferr_r;
  logic [4*ANODES-1:0] digits_r;
  logic [ANODES-1:0]   dots_r;
  logic [ANODES-1:0]   blank_r;
  logic                frame_valid_r;
  logic                code_err_r;
  logic                overlap_r;

  logic [ANODES-1:0]   an_act_s;
  logic [SEG_7-1:0]    seg_act_s;
  logic                changed_s;
  logic                eval_s;
  logic                one_hot_s;
  logic                capture_s;
  logic                overlap_set_s;
  logic [IW-1:0]       pos_s;
  logic [3:0]          dec_val_s;
  logic                dec_blank_s;
  logic                dec_inv_s;

  // Evaluate the sampled pattern: polarity, stability, anode count and position
  always_comb begin
    an_act_s  = smp_r[SW-1 -: ANODES] ^ {ANODES{~ANODE_ON}};
    seg_act_s = smp_r[SEG_7-1:0] ^ {SEG_7{~SEG_ON}};
    changed_s = (smp_r != prev_r);
    // Requiring smp == prev keeps a pattern that changes on the evaluation edge from slipping in.
    eval_s    = (state_r == SETTLE) && !changed_s && (cnt_r == CW'(STABLE_CYC));
    one_hot_s = (an_act_s != {ANODES{1'b0}}) &&
                ((an_act_s & (an_act_s - {{(ANODES-1){1'b0}}, 1'b1})) == {ANODES{1'b0}});
    capture_s     = eval_s && one_hot_s;
    overlap_set_s = eval_s && (an_act_s != {ANODES{1'b0}}) && !one_hot_s;
    pos_s = {IW{1'b0}};
    for (int i = 0; i < ANODES; i++) begin
      pos_s = an_act_s[i] ? IW'(i) : pos_s;
    end
  end

  seg7_pattern_decode u_decode (
    .pattern (seg_act_s[SEG_G:SEG_A]),
    .value   (dec_val_s),
    .blank   (dec_blank_s),
    .invalid (dec_inv_s)
  );

  // Input sampling, stability counter and settle/held state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_r   <= IDLE_SMP;
      prev_r  <= IDLE_SMP;
      cnt_r   <= {CW{1'b0}};
      state_r <= SETTLE;
    end else begin
      smp_r  <= {bus.anodes, bus.segments};
      prev_r <= smp_r;
      if (changed_s) begin
        cnt_r <= {{(CW-1){1'b0}}, 1'b1};
      end else if (cnt_r != CW'(STABLE_CYC)) begin
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
      case (state_r)
        SETTLE:  state_r <= eval_s ? HELD : SETTLE;
        HELD:    state_r <= changed_s ? SETTLE : HELD;
        default: state_r <= SETTLE;
      endcase
    end
  end

  // Per-position capture, frame bookkeeping and error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_r        <= {ANODES{1'b0}};
      ferr_r        <= 1'b0;
      digits_r      <= {(4*ANODES){1'b0}};
      dots_r        <= {ANODES{1'b0}};
      blank_r       <= {ANODES{1'b1}};
      frame_valid_r <= 1'b0;
      code_err_r    <= 1'b0;
      overlap_r     <= 1'b0;
    end else begin
      if (capture_s) begin
        digits_r[4*pos_s +: 4] <= dec_inv_s ? 4'h0 : dec_val_s;
        dots_r[pos_s]          <= seg_act_s[SEG_DP];
        blank_r[pos_s]         <= dec_blank_s;
      end else begin
        digits_r <= digits_r;
        dots_r   <= dots_r;
        blank_r  <= blank_r;
      end
      // A capture landing on the frame-close edge opens the next frame.
      if (&seen_r) begin
        frame_valid_r <= 1'b1;
        code_err_r    <= ferr_r;
        seen_r        <= capture_s ? an_act_s : {ANODES{1'b0}};
        ferr_r        <= capture_s && dec_inv_s;
      end else begin
        frame_valid_r <= 1'b0;
        code_err_r    <= code_err_r;
        seen_r        <= capture_s ? (seen_r | an_act_s) : seen_r;
        ferr_r        <= ferr_r | (capture_s && dec_inv_s);
      end
      if (bus.err_clr) begin
        overlap_r <= 1'b0;
      end else if (overlap_set_s) begin
        overlap_r <= 1'b1;
      end else begin
        overlap_r <= overlap_r;
      end
    end
  end

  assign bus.digits      = digits_r;
  assign bus.dots        = dots_r;
  assign bus.blank       = blank_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.code_err    = code_err_r;
  assign bus.overlap_err = overlap_r;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: drives scan patterns through the interface
// and compares the reconstructed display state against hand-computed values.
module tb_seg7_scan_decoder;

  localparam int N = 16;

  logic clk;
  logic rst_n;
  int   err_cnt;
  int   chk_cnt;
  int   fv_cnt;
  logic fv_code_err;

  seg7_scan_decoder_if #(.ANODES(4), .SEG_7(8)) bus ();

  seg7_scan_decoder #(.ANODES(4), .SEG_7(8), .STABLE_CYC(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_valid pulses and remember the code_err delivered with each.
  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) begin
      fv_cnt      = fv_cnt + 1;
      fv_code_err = bus.code_err;
    end
  end

  // Drive one scan pattern (active-high glyph, dp) on the active-low lines for ncyc cycles.
  task automatic drive(input logic [3:0] an, input logic [6:0] pat, input logic dp, input int ncyc);
    bus.anodes   = an;
    bus.segments = ~{dp, pat};
    repeat (ncyc) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int ncyc);
    drive(4'b1111, 7'h00, 1'b0, ncyc);
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    bus.err_clr = 1'b0;
    bus.anodes  = 4'b1111;
    bus.segments = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++; if (bus.digits !== 16'h0000) begin err_cnt++; $display("FAIL reset_digits got=%h exp=%h", bus.digits, 16'h0000); end
    chk_cnt++; if (bus.dots !== 4'b0000) begin err_cnt++; $display("FAIL reset_dots got=%b exp=%b", bus.dots, 4'b0000); end
    chk_cnt++; if (bus.blank !== 4'b1111) begin err_cnt++; $display("FAIL reset_blank got=%b exp=%b", bus.blank, 4'b1111); end
    chk_cnt++; if (bus.frame_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_fv got=%b exp=0", bus.frame_valid); end
    chk_cnt++; if (bus.code_err !== 1'b0) begin err_cnt++; $display("FAIL reset_code_err got=%b exp=0", bus.code_err); end
    chk_cnt++; if (bus.overlap_err !== 1'b0) begin err_cnt++; $display("FAIL reset_overlap got=%b exp=0", bus.overlap_err); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(30);
  endtask

  task automatic test_single;
    int fv0;
    fv0 = fv_cnt;
    bus.anodes   = 4'b1110;
    bus.segments = ~{1'b0, 7'h4F};
    // First posedge samples the pattern; update is due STABLE_CYC+1 edges after that one.
    repeat (N + 1) @(posedge clk);
    @(negedge clk);
    chk_cnt++; if (bus.digits[3:0] !== 4'h0) begin err_cnt++; $display("FAIL single_early got=%h exp=%h", bus.digits[3:0], 4'h0); end
    @(posedge clk);
    @(negedge clk);
    chk_cnt++; if (bus.digits[3:0] !== 4'h3) begin err_cnt++; $display("FAIL single_digit got=%h exp=%h", bus.digits[3:0], 4'h3); end
    chk_cnt++; if (bus.dots[0] !== 1'b0) begin err_cnt++; $display("FAIL single_dot got=%b exp=0", bus.dots[0]); end
    chk_cnt++; if (bus.blank !== 4'b1110) begin err_cnt++; $display("FAIL single_blank got=%b exp=%b", bus.blank, 4'b1110); end
    @(posedge clk); #1;
    idle(10);
    chk_cnt++; if (fv_cnt != fv0) begin err_cnt++; $display("FAIL single_no_fv got=%0d exp=%0d", fv_cnt - fv0, 0); end
  endtask

  task automatic test_full_frame;
    int fv0;
    fv0 = fv_cnt;
    drive(4'b1110, 7'h71, 1'b0, 40);
    drive(4'b1101, 7'h3F, 1'b0, 40);
    drive(4'b1011, 7'h77, 1'b1, 40);
    drive(4'b0111, 7'h06, 1'b0, 40);
    idle(5);
    chk_cnt++; if (fv_cnt - fv0 != 1) begin err_cnt++; $display("FAIL frame_pulses got=%0d exp=%0d", fv_cnt - fv0, 1); end
    chk_cnt++; if (bus.digits !== 16'h1A0F) begin err_cnt++; $display("FAIL frame_digits got=%h exp=%h", bus.digits, 16'h1A0F); end
    chk_cnt++; if (bus.dots !== 4'b0100) begin err_cnt++; $display("FAIL frame_dots got=%b exp=%b", bus.dots, 4'b0100); end
    chk_cnt++; if (bus.blank !== 4'b0000) begin err_cnt++; $display("FAIL frame_blank got=%b exp=%b", bus.blank, 4'b0000); end
    chk_cnt++; if (fv_code_err !== 1'b0) begin err_cnt++; $display("FAIL frame_code_err got=%b exp=0", fv_code_err); end
  endtask

  task automatic test_glitch;
    int fv0;
    fv0 = fv_cnt;
    drive(4'b1110, 7'h7F, 1'b1, 5);
    idle(40);
    chk_cnt++; if (bus.digits !== 16'h1A0F) begin err_cnt++; $display("FAIL glitch_digits got=%h exp=%h", bus.digits, 16'h1A0F); end
    chk_cnt++; if (bus.dots !== 4'b0100) begin err_cnt++; $display("FAIL glitch_dots got=%b exp=%b", bus.dots, 4'b0100); end
    chk_cnt++; if (fv_cnt != fv0) begin err_cnt++; $display("FAIL glitch_fv got=%0d exp=%0d", fv_cnt - fv0, 0); end
  endtask

  task automatic test_code_err;
    int fv0;
    fv0 = fv_cnt;
    drive(4'b1110, 7'h6D, 1'b0, 40);
    drive(4'b1101, 7'h01, 1'b0, 40);
    drive(4'b1011, 7'h5B, 1'b0, 40);
    drive(4'b0111, 7'h07, 1'b0, 40);
    idle(5);
    chk_cnt++; if (fv_cnt - fv0 != 1) begin err_cnt++; $display("FAIL bad_pulses got=%0d exp=%0d", fv_cnt - fv0, 1); end
    chk_cnt++; if (fv_code_err !== 1'b1) begin err_cnt++; $display("FAIL bad_code_err got=%b exp=1", fv_code_err); end
    chk_cnt++; if (bus.digits !== 16'h7205) begin err_cnt++; $display("FAIL bad_digits got=%h exp=%h", bus.digits, 16'h7205); end
    chk_cnt++; if (bus.blank !== 4'b0000) begin err_cnt++; $display("FAIL bad_blank got=%b exp=%b", bus.blank, 4'b0000); end
    fv0 = fv_cnt;
    drive(4'b1110, 7'h5E, 1'b0, 40);
    drive(4'b1101, 7'h6F, 1'b0, 40);
    drive(4'b1011, 7'h00, 1'b0, 40);
    drive(4'b0111, 7'h7C, 1'b0, 40);
    idle(5);
    chk_cnt++; if (fv_cnt - fv0 != 1) begin err_cnt++; $display("FAIL clean_pulses got=%0d exp=%0d", fv_cnt - fv0, 1); end
    chk_cnt++; if (fv_code_err !== 1'b0) begin err_cnt++; $display("FAIL clean_code_err got=%b exp=0", fv_code_err); end
    chk_cnt++; if (bus.digits !== 16'hB09D) begin err_cnt++; $display("FAIL clean_digits got=%h exp=%h", bus.digits, 16'hB09D); end
    chk_cnt++; if (bus.blank !== 4'b0100) begin err_cnt++; $display("FAIL clean_blank got=%b exp=%b", bus.blank, 4'b0100); end
  endtask

  task automatic test_overlap;
    int fv0;
    fv0 = fv_cnt;
    drive(4'b1100, 7'h06, 1'b0, 25);
    idle(5);
    chk_cnt++; if (bus.overlap_err !== 1'b1) begin err_cnt++; $display("FAIL ovl_set got=%b exp=1", bus.overlap_err); end
    chk_cnt++; if (bus.digits !== 16'hB09D) begin err_cnt++; $display("FAIL ovl_digits got=%h exp=%h", bus.digits, 16'hB09D); end
    // Positions 0/1 must not have been marked seen by the overlap.
    drive(4'b1011, 7'h06, 1'b0, 40);
    drive(4'b0111, 7'h06, 1'b0, 40);
    idle(5);
    chk_cnt++; if (fv_cnt != fv0) begin err_cnt++; $display("FAIL ovl_no_seen got=%0d exp=%0d", fv_cnt - fv0, 0); end
    chk_cnt++; if (bus.digits !== 16'h119D) begin err_cnt++; $display("FAIL ovl_partial got=%h exp=%h", bus.digits, 16'h119D); end
    bus.err_clr = 1'b1;
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
    @(negedge clk);
    chk_cnt++; if (bus.overlap_err !== 1'b0) begin err_cnt++; $display("FAIL ovl_clr got=%b exp=0", bus.overlap_err); end
    @(posedge clk); #1;
    drive(4'b1110, 7'h39, 1'b0, 40);
    drive(4'b1101, 7'h4F, 1'b0, 40);
    idle(5);
    chk_cnt++; if (fv_cnt - fv0 != 1) begin err_cnt++; $display("FAIL ovl_frame got=%0d exp=%0d", fv_cnt - fv0, 1); end
    chk_cnt++; if (bus.digits !== 16'h113C) begin err_cnt++; $display("FAIL ovl_frame_digits got=%h exp=%h", bus.digits, 16'h113C); end
    drive(4'b1010, 7'h3F, 1'b0, 25);
    idle(5);
    chk_cnt++; if (bus.overlap_err !== 1'b1) begin err_cnt++; $display("FAIL ovl_reassert got=%b exp=1", bus.overlap_err); end
  endtask

  task automatic test_reset_mid;
    int fv0;
    drive(4'b1110, 7'h66, 1'b1, 40);
    drive(4'b1101, 7'h7D, 1'b0, 40);
    #3;
    rst_n = 1'b0;
    bus.anodes   = 4'b1111;
    bus.segments = 8'hFF;
    #1;
    chk_cnt++; if (bus.digits !== 16'h0000) begin err_cnt++; $display("FAIL rmid_digits got=%h exp=%h", bus.digits, 16'h0000); end
    chk_cnt++; if (bus.dots !== 4'b0000) begin err_cnt++; $display("FAIL rmid_dots got=%b exp=%b", bus.dots, 4'b0000); end
    chk_cnt++; if (bus.blank !== 4'b1111) begin err_cnt++; $display("FAIL rmid_blank got=%b exp=%b", bus.blank, 4'b1111); end
    chk_cnt++; if (bus.overlap_err !== 1'b0) begin err_cnt++; $display("FAIL rmid_overlap got=%b exp=0", bus.overlap_err); end
    chk_cnt++; if (bus.frame_valid !== 1'b0) begin err_cnt++; $display("FAIL rmid_fv got=%b exp=0", bus.frame_valid); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(30);
    fv0 = fv_cnt;
    drive(4'b1011, 7'h77, 1'b0, 40);
    drive(4'b0111, 7'h71, 1'b0, 40);
    idle(5);
    chk_cnt++; if (fv_cnt != fv0) begin err_cnt++; $display("FAIL rmid_partial got=%0d exp=%0d", fv_cnt - fv0, 0); end
    drive(4'b1110, 7'h06, 1'b0, 40);
    drive(4'b1101, 7'h5B, 1'b0, 40);
    idle(5);
    chk_cnt++; if (fv_cnt - fv0 != 1) begin err_cnt++; $display("FAIL rmid_frame got=%0d exp=%0d", fv_cnt - fv0, 1); end
    chk_cnt++; if (bus.digits !== 16'hFA21) begin err_cnt++; $display("FAIL rmid_digits_after got=%h exp=%h", bus.digits, 16'hFA21); end
  endtask

  initial begin
    err_cnt     = 0;
    chk_cnt     = 0;
    fv_cnt      = 0;
    fv_code_err = 1'b0;
    test_reset();
    test_single();
    test_full_frame();
    test_glitch();
    test_code_err();
    test_overlap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive end of the multiplexed 7-segment interface: samples the `anodes`/`segments` lines produced by the display scanner and reconstructs the shown hex digit, decimal point and blank state per position.
- Used as an on-board self-check and bench monitor alongside the calculator top.
- Flags illegal scan states: several anodes active at once, or an undecodable segment pattern.

Parameters:
- ANODES, 4, number of multiplexed digit positions.
- SEG_7, 8, segment lines; bit 7 = dp, bits 6..0 = g,f,e,d,c,b,a.
- STABLE_CYC, 16, consecutive identical samples required before a pattern is captured; legal range 2..255.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- anodes, in, ANODES, digit enables, active-low.
- segments, in, SEG_7, segment drives, active-low.
- digits, out, 4*ANODES, decoded hex value per position; position i is in bits [4i+3:4i].
- dots, out, ANODES, dp state per position (1 = lit).
- blank, out, ANODES, 1 = position captured with all of a..g off.
- frame_valid, out, 1, one-cycle pulse when every position has been captured since the last pulse.
- code_err, out, 1, a pattern in the last completed frame was undecodable.
- overlap_err, out, 1, sticky; set when more than one anode is active in a stable pattern.
- err_clr, in, 1, synchronous clear of overlap_err.

Behaviour:
- Reset (async assert, sync release):
  - digits = 0, dots = 0, blank = all ones.
  - frame_valid = 0, code_err = 0, overlap_err = 0.
  - seen mask = 0, stability counter = 0, state = SETTLE.
- Input stage: `{anodes, segments}` is registered once into `smp` every cycle; `prev` holds the prior `smp`.
- Stability counter:
  - Width $clog2(STABLE_CYC+1); saturates at STABLE_CYC.
  - Cleared to 1 whenever `smp != prev`; otherwise increments.
- FSM, two states:
  - SETTLE: when count reaches STABLE_CYC, evaluate `smp` and go to HELD.
  - HELD: stay until `smp != prev`, then go to SETTLE. Each stable pattern is evaluated exactly once, no matter how long it persists.
- Evaluation, at the single edge where SETTLE→HELD:
  - All anodes inactive (all ones): no capture, no error.
  - Exactly one anode low at position i:
    - Decode `~segments[6:0]` and write digits[i], dots[i] = ~segments[7], blank[i].
    - Set seen[i].
    - If the pattern is undecodable: digits[i] = 0, blank[i] = 0, set the frame error latch.
  - Two or more anodes low: no capture; set overlap_err.
- Latency: with inputs held constant from edge k, outputs update at edge k+STABLE_CYC+1.
- Frame completion:
  - On the cycle after seen becomes all ones, pulse frame_valid for one cycle.
  - At the same time: code_err ← frame error latch, clear the latch, clear seen.
  - A capture on the same edge as the clear sets its seen bit in the new frame. That capture's error is included in the new frame's latch.
- Re-capturing a position before the frame completes overwrites its outputs and leaves seen unchanged.
- err_clr has priority over a simultaneous overlap set: the clear wins, and the error re-asserts on the next overlapping capture.
- Decode table (active-high gfedcba → value):
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7.
  - 0x7F→8, 0x6F→9, 0x77→A, 0x7C→b, 0x39→C, 0x5E→d, 0x79→E, 0x71→F.
  - 0x00 → blank.
  - Any other pattern → error.
- Reset mid-frame discards partial captures; outputs return to their reset values immediately.

Decomposition:
- Shared package `seg7_pkg`:
  - The 16 segment pattern constants and the blank constant.
  - The segment bit-index constants (dp = 7).
  - The active-low polarity constants, so the scanner and decoder share one definition.
- Sub-module `seg7_pattern_decode`:
  - Purely combinational.
  - 7-bit active-high pattern in; 4-bit value, blank and invalid out.

Test Plan:
- Single position: reset, then drive anodes=1110, segments=~0x4F (dp off), held for 17 cycles.
  - digits[3:0]=3 at edge STABLE_CYC+1; dots[0]=0, blank[0]=0; no frame_valid.
- Full frame: scan "1A0F" with 40 cycles per digit, dp on position 2.
  - One frame_valid pulse after the 4th capture.
  - digits=16'h1A0F, dots=4'b0100, code_err=0.
- Glitch rejection: a 5-cycle pattern (< STABLE_CYC) inserted between digits.
  - No capture; outputs unchanged.
- Undecodable pattern: position 1 driven with segments=~0x01 inside an otherwise valid frame.
  - digits[7:4]=0; code_err=1 at that frame's pulse.
  - Next clean frame gives code_err=0.
- Overlap: anodes=1100 held for 20 cycles.
  - overlap_err=1, no seen bits set.
  - err_clr for 1 cycle gives overlap_err=0.
- Async reset asserted mid-frame after 2 captures.
  - Outputs at reset values immediately.
  - After release, a full frame is required before frame_valid.
